// File: rtl/tone_contour_generator_pkg.sv
// Shared tone definitions: tone codes, contour directions, playback states and
// the mapping from a tone code to the direction of each segment change.
package tone_pkg;

  localparam logic [2:0] TONE_NEUTRAL    = 3'b000;
  localparam logic [2:0] TONE_RISING     = 3'b001;
  localparam logic [2:0] TONE_UNDULATING = 3'b010;
  localparam logic [2:0] TONE_FALLING    = 3'b100;

  typedef enum logic [1:0] {
    FLAT = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } state_t;

  // Direction applied at each segment change: seg0->1, seg1->2, seg2->3.
  typedef struct packed {
    dir_t change0;
    dir_t change1;
    dir_t change2;
  } dir_triple_t;

  function automatic logic tone_is_valid(input logic [2:0] code);
    return (code == TONE_NEUTRAL) || (code == TONE_RISING) ||
           (code == TONE_UNDULATING) || (code == TONE_FALLING);
  endfunction

  function automatic dir_triple_t tone_directions(input logic [2:0] code);
    dir_triple_t dirs;
    case (code)
      TONE_RISING:     dirs = '{change0: UP,   change1: UP,   change2: UP};
      TONE_UNDULATING: dirs = '{change0: UP,   change1: UP,   change2: DOWN};
      TONE_FALLING:    dirs = '{change0: DOWN, change1: DOWN, change2: DOWN};
      default:         dirs = '{change0: FLAT, change1: FLAT, change2: FLAT};
    endcase
    return dirs;
  endfunction

endpackage

// File: rtl/tone_contour_generator_step.sv
// Combinational pitch step: moves a 32-bit DDS increment up or down by
// inc>>STEP_SHIFT, saturating at all-ones on the way up.
module tone_step
  import tone_pkg::*;
#(
  parameter int STEP_SHIFT = 2
) (
  input  logic [31:0] inc,
  input  dir_t        dir,
  output logic [31:0] result
);

  logic [31:0] delta;
  logic [32:0] up_sum;

  assign delta  = inc >> STEP_SHIFT;
  assign up_sum = {1'b0, inc} + {1'b0, delta};

  // Select the stepped increment; a carry out of the 33-bit sum clamps to max.
  always_comb begin
    result = inc;
    case (dir)
      UP:      result = up_sum[32] ? 32'hFFFF_FFFF : up_sum[31:0];
      DOWN:    result = inc - delta;
      default: result = inc;
    endcase
  end

endmodule

// File: rtl/tone_contour_generator.sv
// Tone contour generator: plays a four-segment pitch contour for a requested
// tone as a stream of DDS phase increments plus an 8-bit sawtooth sample.
module tone_contour_generator
  import tone_pkg::*;
#(
  parameter int STEP_SHIFT   = 2,
  parameter int NUM_SEGMENTS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [2:0]  tone_ident_in,
  input  logic [31:0] base_inc_in,
  input  logic [31:0] segment_length_in,
  output logic        ready_out,
  output logic        phase_valid_out,
  output logic [31:0] phase_inc_out,
  output logic [7:0]  sample_out,
  output logic [1:0]  segment_idx_out,
  output logic        done_out,
  output logic        error_out
);

  localparam logic [1:0] LAST_SEGMENT = 2'(NUM_SEGMENTS - 1);

  state_t      state, state_next;

  logic [31:0] base_q, base_next;
  logic [31:0] last_cnt_q, last_cnt_next;
  dir_triple_t dirs_q, dirs_next;
  logic [31:0] phase_inc_q, phase_inc_next;
  logic [31:0] acc_q, acc_next;
  logic [1:0]  seg_q, seg_next;
  logic [31:0] cnt_q, cnt_next;
  logic        valid_q, valid_next;
  logic        done_q, done_next;
  logic        error_q, error_next;

  dir_t        cur_dir;
  logic [31:0] stepped_inc;

  tone_step #(
    .STEP_SHIFT(STEP_SHIFT)
  ) u_step (
    .inc    (phase_inc_q),
    .dir    (cur_dir),
    .result (stepped_inc)
  );

  // Pick the direction for the change that leaves the current segment.
  always_comb begin
    cur_dir = FLAT;
    case (seg_q)
      2'd0:    cur_dir = dirs_q.change0;
      2'd1:    cur_dir = dirs_q.change1;
      default: cur_dir = dirs_q.change2;
    endcase
  end

  // Playback state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-datapath decode; the segment length is stored as its
  // last counter value so a length of 0 behaves like 1.
  always_comb begin
    state_next     = state;
    base_next      = base_q;
    last_cnt_next  = last_cnt_q;
    dirs_next      = dirs_q;
    phase_inc_next = phase_inc_q;
    acc_next       = acc_q;
    seg_next       = seg_q;
    cnt_next       = cnt_q;
    valid_next     = 1'b0;
    done_next      = 1'b0;
    error_next     = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in) begin
          if (tone_is_valid(tone_ident_in)) begin
            state_next    = LOAD;
            base_next     = base_inc_in;
            last_cnt_next = (segment_length_in == 32'd0) ? 32'd0 : segment_length_in - 32'd1;
            dirs_next     = tone_directions(tone_ident_in);
          end else begin
            error_next = 1'b1;
          end
        end
      end
      LOAD: begin
        phase_inc_next = base_q;
        acc_next       = 32'd0;
        seg_next       = 2'd0;
        cnt_next       = 32'd0;
        valid_next     = 1'b1;
        state_next     = PLAY;
      end
      PLAY: begin
        acc_next = acc_q + phase_inc_q;
        if (cnt_q == last_cnt_q) begin
          if (seg_q == LAST_SEGMENT) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            seg_next       = seg_q + 2'd1;
            cnt_next       = 32'd0;
            phase_inc_next = stepped_inc;
            valid_next     = 1'b1;
          end
        end else begin
          cnt_next   = cnt_q + 32'd1;
          valid_next = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and registered output flags.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      base_q      <= 32'd0;
      last_cnt_q  <= 32'd0;
      dirs_q      <= '{change0: FLAT, change1: FLAT, change2: FLAT};
      phase_inc_q <= 32'd0;
      acc_q       <= 32'd0;
      seg_q       <= 2'd0;
      cnt_q       <= 32'd0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      base_q      <= base_next;
      last_cnt_q  <= last_cnt_next;
      dirs_q      <= dirs_next;
      phase_inc_q <= phase_inc_next;
      acc_q       <= acc_next;
      seg_q       <= seg_next;
      cnt_q       <= cnt_next;
      valid_q     <= valid_next;
      done_q      <= done_next;
      error_q     <= error_next;
    end
  end

  assign ready_out       = (state == IDLE);
  assign phase_valid_out = valid_q;
  assign phase_inc_out   = phase_inc_q;
  assign sample_out      = acc_q[31:24];
  assign segment_idx_out = seg_q;
  assign done_out        = done_q;
  assign error_out       = error_q;

endmodule

// File: tb/tb_tone_contour_generator.sv
// Bench for tone_contour_generator: directed table of tones, invalid-code and
// reset corner cases, and randomized requests against a contour model.
module tb_tone_contour_generator;

  localparam int STEP_SHIFT = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic [2:0]  tone_ident_in;
  logic [31:0] base_inc_in;
  logic [31:0] segment_length_in;
  logic        ready_out;
  logic        phase_valid_out;
  logic [31:0] phase_inc_out;
  logic [7:0]  sample_out;
  logic [1:0]  segment_idx_out;
  logic        done_out;
  logic        error_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] inc;
    logic [7:0]  sample;
    logic [1:0]  seg;
  } exp_cycle_t;

  typedef struct {
    string       name;
    logic [2:0]  code;
    logic [31:0] base;
    logic [31:0] len;
    logic [31:0] inc0;
    logic [31:0] inc1;
    logic [31:0] inc2;
    logic [31:0] inc3;
    int          count;
  } vec_t;

  tone_contour_generator #(
    .STEP_SHIFT(STEP_SHIFT),
    .NUM_SEGMENTS(4)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .valid_in          (valid_in),
    .tone_ident_in     (tone_ident_in),
    .base_inc_in       (base_inc_in),
    .segment_length_in (segment_length_in),
    .ready_out         (ready_out),
    .phase_valid_out   (phase_valid_out),
    .phase_inc_out     (phase_inc_out),
    .sample_out        (sample_out),
    .segment_idx_out   (segment_idx_out),
    .done_out          (done_out),
    .error_out         (error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Contour direction of change n for a tone: +1 up, -1 down, 0 flat.
  function automatic int modelDir(input logic [2:0] code, input int change);
    case (code)
      3'b001:  return 1;
      3'b100:  return -1;
      3'b010:  return (change == 2) ? -1 : 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] modelStep(input logic [31:0] inc, input int dir);
    longint unsigned wide;
    logic [31:0] quarter;
    quarter = inc >> STEP_SHIFT;
    if (dir > 0) begin
      wide = longint'(inc) + longint'(quarter);
      if (wide > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
      return wide[31:0];
    end
    if (dir < 0) return inc - quarter;
    return inc;
  endfunction

  function automatic logic isValidCode(input logic [2:0] code);
    return (code == 3'b000) || (code == 3'b001) || (code == 3'b010) || (code == 3'b100);
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(ready_out), 32'd1);
    checkOutput({tag, "_phase_valid"}, 32'(phase_valid_out), 32'd0);
    checkOutput({tag, "_phase_inc"}, phase_inc_out, 32'd0);
    checkOutput({tag, "_sample"}, 32'(sample_out), 32'd0);
    checkOutput({tag, "_seg"}, 32'(segment_idx_out), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_out), 32'd0);
    checkOutput({tag, "_error"}, 32'(error_out), 32'd0);
  endtask

  // Issue one valid request at the current negedge and follow the whole
  // playback cycle by cycle against the contour model.
  task automatic applyStimulus(input logic [2:0] code, input logic [31:0] base, input logic [31:0] len,
                               output logic [3:0][31:0] segIncs, output int validCount);
    exp_cycle_t expQ[$];
    logic [31:0] inc;
    logic [31:0] acc;
    int effLen;
    effLen = (len == 32'd0) ? 1 : int'(len);
    inc = base;
    acc = 32'd0;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < effLen; c++) begin
        expQ.push_back('{inc: inc, sample: acc[31:24], seg: 2'(s)});
        acc = acc + inc;
      end
      if (s < 3) inc = modelStep(inc, modelDir(code, s));
    end
    segIncs = '0;
    validCount = 0;

    checkOutput("ready_before_accept", 32'(ready_out), 32'd1);
    valid_in = 1'b1;
    tone_ident_in = code;
    base_inc_in = base;
    segment_length_in = len;
    @(negedge clk_in);
    valid_in = 1'b0;
    base_inc_in = $urandom;
    segment_length_in = 32'($urandom_range(0, 7));
    tone_ident_in = 3'($urandom_range(0, 7));
    checkOutput("load_ready", 32'(ready_out), 32'd0);
    checkOutput("load_phase_valid", 32'(phase_valid_out), 32'd0);
    checkOutput("load_error", 32'(error_out), 32'd0);
    @(negedge clk_in);
    for (int i = 0; i < expQ.size(); i++) begin
      checkOutput("play_valid", 32'(phase_valid_out), 32'd1);
      checkOutput("play_inc", phase_inc_out, expQ[i].inc);
      checkOutput("play_sample", 32'(sample_out), 32'(expQ[i].sample));
      checkOutput("play_seg", 32'(segment_idx_out), 32'(expQ[i].seg));
      checkOutput("play_done_low", 32'(done_out), 32'd0);
      if (phase_valid_out === 1'b1) validCount++;
      if (i == 0 || expQ[i].seg != expQ[i-1].seg) segIncs[expQ[i].seg] = phase_inc_out;
      valid_in = (i == expQ.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      tone_ident_in = 3'($urandom_range(0, 7));
      @(negedge clk_in);
    end
    valid_in = 1'b0;
    checkOutput("done_pulse", 32'(done_out), 32'd1);
    checkOutput("done_phase_valid", 32'(phase_valid_out), 32'd0);
    checkOutput("done_ready", 32'(ready_out), 32'd0);
    @(negedge clk_in);
    checkOutput("after_done_low", 32'(done_out), 32'd0);
    checkOutput("after_done_ready", 32'(ready_out), 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    logic [3:0][31:0] segIncs;
    int validCount;
    int doneSeen;
    logic [2:0] code;

    vecs[0] = '{"rising",     3'b001, 32'h1000_0000, 32'd4, 32'h1000_0000, 32'h1400_0000, 32'h1900_0000, 32'h1F40_0000, 16};
    vecs[1] = '{"falling",    3'b100, 32'h1000_0000, 32'd4, 32'h1000_0000, 32'h0C00_0000, 32'h0900_0000, 32'h06C0_0000, 16};
    vecs[2] = '{"undulating", 3'b010, 32'h1000_0000, 32'd2, 32'h1000_0000, 32'h1400_0000, 32'h1900_0000, 32'h12C0_0000, 8};
    vecs[3] = '{"saturate",   3'b001, 32'hF000_0000, 32'd1, 32'hF000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4};
    vecs[4] = '{"neutral_l0", 3'b000, 32'h0123_4567, 32'd0, 32'h0123_4567, 32'h0123_4567, 32'h0123_4567, 32'h0123_4567, 4};

    rst_in = 1'b1;
    valid_in = 1'b0;
    tone_ident_in = 3'b000;
    base_inc_in = 32'd0;
    segment_length_in = 32'd0;
    @(negedge clk_in);
    @(negedge clk_in);
    checkResetOutputs("reset");
    rst_in = 1'b0;
    @(negedge clk_in);
    checkResetOutputs("post_reset");

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].code, vecs[v].base, vecs[v].len, segIncs, validCount);
      checkOutput({vecs[v].name, "_seg0"}, segIncs[0], vecs[v].inc0);
      checkOutput({vecs[v].name, "_seg1"}, segIncs[1], vecs[v].inc1);
      checkOutput({vecs[v].name, "_seg2"}, segIncs[2], vecs[v].inc2);
      checkOutput({vecs[v].name, "_seg3"}, segIncs[3], vecs[v].inc3);
      checkOutput({vecs[v].name, "_count"}, 32'(validCount), 32'(vecs[v].count));
    end

    $display("[TB] invalid code then immediate valid request");
    valid_in = 1'b1;
    tone_ident_in = 3'b011;
    base_inc_in = 32'h1000_0000;
    segment_length_in = 32'd4;
    @(negedge clk_in);
    valid_in = 1'b0;
    checkOutput("invalid_error", 32'(error_out), 32'd1);
    checkOutput("invalid_ready", 32'(ready_out), 32'd1);
    checkOutput("invalid_phase_valid", 32'(phase_valid_out), 32'd0);
    applyStimulus(3'b001, 32'h1000_0000, 32'd1, segIncs, validCount);
    checkOutput("after_invalid_count", 32'(validCount), 32'd4);

    $display("[TB] reset during segment 2");
    valid_in = 1'b1;
    tone_ident_in = 3'b001;
    base_inc_in = 32'h1000_0000;
    segment_length_in = 32'd4;
    @(negedge clk_in);
    valid_in = 1'b0;
    for (int i = 0; i < 40 && segment_idx_out !== 2'd2; i++) @(negedge clk_in);
    checkOutput("reach_seg2", 32'(segment_idx_out), 32'd2);
    checkOutput("reach_seg2_valid", 32'(phase_valid_out), 32'd1);
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    checkResetOutputs("mid_play_reset");
    @(negedge clk_in);
    rst_in = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (done_out !== 1'b0 || phase_valid_out !== 1'b0) doneSeen++;
    end
    checkOutput("reset_no_done", 32'(doneSeen), 32'd0);
    checkOutput("reset_ready", 32'(ready_out), 32'd1);

    $display("[TB] randomized requests");
    for (int r = 0; r < 30; r++) begin
      code = 3'($urandom_range(0, 7));
      if (isValidCode(code)) begin
        applyStimulus(code, $urandom, 32'($urandom_range(0, 5)), segIncs, validCount);
      end else begin
        valid_in = 1'b1;
        tone_ident_in = code;
        base_inc_in = $urandom;
        segment_length_in = 32'($urandom_range(0, 5));
        @(negedge clk_in);
        valid_in = 1'b0;
        checkOutput("rand_invalid_error", 32'(error_out), 32'd1);
        checkOutput("rand_invalid_ready", 32'(ready_out), 32'd1);
        checkOutput("rand_invalid_pv", 32'(phase_valid_out), 32'd0);
        @(negedge clk_in);
        checkOutput("rand_invalid_error_low", 32'(error_out), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
